// File: rtl/dac_refresh_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// dac_refresh_sequencer_pkg
// Shared definitions for the DAC refresh sequencer and its setpoint bank.
// CH_W and DATA_W match the ADC input bank, so both banks address channels
// the same way.
// ---------------------------------------------------------------------------
package dac_refresh_sequencer_pkg;

  localparam int CH_W   = 3;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STROBE = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  // First channel set in mask, searching upward from ch with wrap.
  // skip_self=1 starts the search at ch+1. If only ch itself is set, the
  // search goes all the way around and returns ch.
  // If mask is empty, ch is returned unchanged.
  function automatic logic [CH_W-1:0] next_active(
    input logic [CH_W-1:0]        ch,
    input logic [(1<<CH_W)-1:0]   mask,
    input logic                   skip_self
  );
    logic [CH_W-1:0] idx;
    logic [CH_W-1:0] res;
    logic            found;
    res   = ch;
    found = 1'b0;
    for (int i = 0; i <= (1 << CH_W); i++) begin
      idx = ch + CH_W'(i);
      if (!found && !(skip_self && (i == 0)) && mask[idx]) begin
        found = 1'b1;
        res   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dac_refresh_sequencer_bank.sv
// ---------------------------------------------------------------------------
// dac_setpoint_bank
// NUM_CH x DATA_W setpoint register file: one synchronous write port, one
// combinational read port, synchronous active-high reset to all zero.
// Ports:
//   i_clk, i_reset          clock / synchronous reset
//   i_wr_en, i_wr_addr,
//   i_wr_data               write port, applied at the clock edge
//   i_rd_addr, o_rd_data    combinational read port
// ---------------------------------------------------------------------------
module dac_setpoint_bank
  import dac_refresh_sequencer_pkg::*;
#(
  parameter int NUM_CH = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [CH_W-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [CH_W-1:0]   i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [NUM_CH];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read returns the pre-edge contents, so a write landing on the same edge
  // as a LOAD capture is seen only on the next visit to that channel.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/dac_refresh_sequencer.sv
// ---------------------------------------------------------------------------
// dac_refresh_sequencer
// Continuously refreshes eight 8-bit setpoints onto one parallel DAC whose
// output is routed through a 3-bit analog demux into per-channel
// sample-and-hold capacitors. Per channel: LOAD (1 cycle), STROBE
// (dac_wr high STROBE_CYCLES cycles), SETTLE (sh_en high SETTLE_CYCLES cycles).
// Ports:
//   clk, reset              clock / synchronous active-high reset
//   enable                  keep refreshing (sampled in IDLE and at SETTLE exit)
//   wr_en, wr_addr, wr_data setpoint write port, accepted in every state
//   dac_data, dac_wr        DAC value and latch strobe
//   sh_addr, sh_en          demux channel select and sample-and-hold gate
//   busy                    high whenever the FSM is not in IDLE
//   frame_done              one-cycle pulse when the channel advance wraps
// Build option: define DAC_REFRESH_MASK_EN to add ch_mask (1 = channel
// active); inactive channels are skipped and an all-zero mask keeps the
// sequencer idle. Without it every channel is visited in order.
// ---------------------------------------------------------------------------
module dac_refresh_sequencer
  import dac_refresh_sequencer_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int STROBE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 80000
) (
  input  logic              clk,
  input  logic              reset,
`ifdef DAC_REFRESH_MASK_EN
  input  logic [NUM_CH-1:0] ch_mask,
`endif
  input  logic              enable,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_wr,
  output logic [CH_W-1:0]   sh_addr,
  output logic              sh_en,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_MAX = (STROBE_CYCLES > SETTLE_CYCLES) ? STROBE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CH_W-1:0]   r_ch;
  logic [DATA_W-1:0] r_dac_data;
  logic              r_dac_wr;
  logic [CH_W-1:0]   r_sh_addr;
  logic              r_sh_en;
  logic              r_busy;
  logic              r_frame_done;

  logic [NUM_CH-1:0] w_mask;
  logic              w_go;
  logic [CH_W-1:0]   w_first;
  logic [CH_W-1:0]   w_next;
  logic              w_wrap;
  logic [DATA_W-1:0] w_rd_data;

`ifdef DAC_REFRESH_MASK_EN
  assign w_mask = ch_mask;
`else
  assign w_mask = '1;
`endif

  assign w_go    = enable & (|w_mask);
  // Leaving IDLE: the stored channel may have been masked off meanwhile.
  assign w_first = next_active(r_ch, w_mask, 1'b0);
  assign w_next  = next_active(r_ch, w_mask, 1'b1);
  // Advancing to a channel at or below the current one means we passed ch7.
  assign w_wrap  = (w_next <= r_ch);

  dac_setpoint_bank #(
    .NUM_CH (NUM_CH)
  ) u_bank (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_ch),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_ch         <= '0;
      r_dac_data   <= '0;
      r_dac_wr     <= 1'b0;
      r_sh_addr    <= '0;
      r_sh_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
            r_ch    <= w_first;
          end
        end
        ST_LOAD: begin
          r_dac_data <= w_rd_data;
          r_sh_addr  <= r_ch;
          r_dac_wr   <= 1'b1;
          r_cnt      <= STROBE_LD;
          r_state    <= ST_STROBE;
        end
        // Shared down-counter: reloaded on entry, exit on reaching zero.
        ST_STROBE: begin
          if (r_cnt == '0) begin
            r_dac_wr <= 1'b0;
            r_sh_en  <= 1'b1;
            r_cnt    <= SETTLE_LD;
            r_state  <= ST_SETTLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_sh_en      <= 1'b0;
            r_ch         <= w_next;
            r_frame_done <= w_wrap;
            if (w_go) begin
              r_state <= ST_LOAD;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dac_data   = r_dac_data;
  assign dac_wr     = r_dac_wr;
  assign sh_addr    = r_sh_addr;
  assign sh_en      = r_sh_en;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_dac_refresh_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dac_refresh_sequencer
// Directed bench for dac_refresh_sequencer with SETTLE_CYCLES=10 so that a
// channel takes 15 cycles and a frame 120 cycles. Inputs are driven and
// outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_dac_refresh_sequencer;

  localparam int STROBE = 4;
  localparam int SETTLE = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] ch_mask;
  logic [7:0] dac_data;
  logic       dac_wr;
  logic [2:0] sh_addr;
  logic       sh_en;
  logic       busy;
  logic       frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0;

  dac_refresh_sequencer #(
    .NUM_CH        (8),
    .STROBE_CYCLES (STROBE),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef DAC_REFRESH_MASK_EN
    .ch_mask    (ch_mask),
`endif
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dac_data   (dac_data),
    .dac_wr     (dac_wr),
    .sh_addr    (sh_addr),
    .sh_en      (sh_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dac_data"},   dac_data,   32'h0);
    check({tag, "_dac_wr"},     dac_wr,     32'h0);
    check({tag, "_sh_addr"},    sh_addr,    32'h0);
    check({tag, "_sh_en"},      sh_en,      32'h0);
    check({tag, "_busy"},       busy,       32'h0);
    check({tag, "_frame_done"}, frame_done, 32'h0);
  endtask

  // Called on the falling edge inside a LOAD cycle; returns on the falling
  // edge of the cycle after the channel's SETTLE exit.
  task automatic visit(input int ch, input logic [7:0] d, input bit wr_now, input bit drop_en);
    int n_wr;
    int n_sh;
    int first_sh;
    bit overlap;
    n_wr = 0; n_sh = 0; first_sh = -1; overlap = 0;
    check($sformatf("ch%0d_load_busy", ch), busy, 32'h1);
    check($sformatf("ch%0d_load_sh_en", ch), sh_en, 32'h0);
    if (wr_now) begin
      wr_en = 1'b1; wr_addr = 3'(ch); wr_data = 8'h3C;
    end
    for (int k = 1; k <= STROBE + SETTLE; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (k == 1) check($sformatf("ch%0d_fd_width", ch), frame_done, 32'h0);
      if (dac_wr) n_wr++;
      if (sh_en) begin
        n_sh++;
        if (first_sh < 0) first_sh = k;
      end
      if (dac_wr && sh_en) overlap = 1'b1;
      if (drop_en && k == STROBE + 3) enable = 1'b0;
    end
    check($sformatf("ch%0d_dac_data", ch), dac_data, d);
    check($sformatf("ch%0d_sh_addr", ch), sh_addr, ch);
    check($sformatf("ch%0d_wr_cycles", ch), n_wr, STROBE);
    check($sformatf("ch%0d_sh_cycles", ch), n_sh, SETTLE);
    check($sformatf("ch%0d_sh_rise", ch), first_sh, STROBE + 1);
    check($sformatf("ch%0d_overlap", ch), overlap, 32'h0);
    @(negedge clk);
    check($sformatf("ch%0d_frame_done", ch), frame_done, (ch == 7));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    ch_mask = 8'hFF;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
    @(negedge clk);
    wr_addr = 3'd2; wr_data = 8'h11;
    @(negedge clk);
    wr_en = 1'b0;
    check("idle_busy", busy, 32'h0);

    // Frame 1: full run, collision write on ch2's LOAD cycle.
    enable = 1'b1;
    @(negedge clk);
    t0 = cyc;
    visit(0, 8'h00, 0, 0);
    visit(1, 8'h00, 0, 0);
    visit(2, 8'h11, 1, 0);
    visit(3, 8'hA5, 0, 0);
    visit(4, 8'h00, 0, 0);
    visit(5, 8'h00, 0, 0);
    visit(6, 8'h00, 0, 0);
    visit(7, 8'h00, 0, 0);
    check("frame_period", cyc - t0, 32'd120);

    // Frame 2: new ch2 value visible; enable dropped during ch5 SETTLE.
    visit(0, 8'h00, 0, 0);
    visit(1, 8'h00, 0, 0);
    visit(2, 8'h3C, 0, 0);
    visit(3, 8'hA5, 0, 0);
    visit(4, 8'h00, 0, 0);
    visit(5, 8'h00, 0, 1);
    check("stop_busy", busy, 32'h0);
    check("stop_hold_addr", sh_addr, 32'd5);
    repeat (3) @(negedge clk);
    check("stop_stay_idle", busy, 32'h0);
    enable = 1'b1;
    @(negedge clk);
    visit(6, 8'h00, 0, 0);
    visit(7, 8'h00, 0, 0);

    // Reset during STROBE of ch0.
    @(negedge clk);
    check("strobe_before_rst", dac_wr, 32'h1);
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    @(negedge clk);
    check("postrst_idle", busy, 32'h0);
    enable = 1'b1;
    @(negedge clk);
    visit(0, 8'h00, 0, 0);
    visit(1, 8'h00, 0, 0);
    visit(2, 8'h00, 0, 0);
    visit(3, 8'h00, 0, 1);
    check("postrst_stop", busy, 32'h0);

`ifdef DAC_REFRESH_MASK_EN
    ch_mask = 8'h00; enable = 1'b1;
    repeat (4) @(negedge clk);
    check("mask0_idle", busy, 32'h0);
    ch_mask = 8'b1000_0010;
    @(negedge clk);
    visit(7, 8'h00, 0, 0);
    visit(1, 8'h00, 0, 0);
    visit(7, 8'h00, 0, 1);
    check("mask_stop", busy, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_refresh_sequencer.md
# dac_refresh_sequencer

Output-side counterpart to the ADC sample bank: holds eight 8-bit channel setpoints written by the processor and continuously refreshes them onto a single parallel 8-bit DAC, routing its output through a 3-bit analog demux into per-channel sample-and-hold capacitors. It sits between the processor's memory-mapped write path and the board-level DAC/demux pins, mirroring the ADC input bank's channel addressing (3-bit address, channel 0..7).

## Interface
- NUM_CH, 8: number of channels; address width fixed at 3 bits.
- STROBE_CYCLES, 4: cycles `dac_wr` is held high per channel (≥1).
- SETTLE_CYCLES, 80000: cycles `sh_en` is held high per channel (≥1).
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = keep refreshing, 0 = stop after the current channel.
- wr_en  in  1  setpoint write strobe, one cycle.
- wr_addr  in  3  channel to write.
- wr_data  in  8  setpoint value.
- dac_data  out  8  value presented to the DAC.
- dac_wr  out  1  DAC latch strobe, active high.
- sh_addr  out  3  demux / sample-and-hold channel select.
- sh_en  out  1  sample-and-hold gate for `sh_addr`.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when channel 7 finishes SETTLE.

## Operation
- Setpoint bank: 8 x 8-bit registers; `wr_en` writes `wr_data` to `wr_addr` at the clock edge; writes are accepted in every state.
- FSM states: IDLE, LOAD, STROBE, SETTLE.
- IDLE: `busy`=0. If `enable`=1, go to LOAD.
- LOAD, 1 cycle: `dac_data` <= bank[ch]; `sh_addr` <= ch; go to STROBE.
- STROBE: `dac_wr`=1 for exactly STROBE_CYCLES cycles, then SETTLE.
- SETTLE: `sh_en`=1 for exactly SETTLE_CYCLES cycles. On exit, ch <= ch+1 with wrap 7->0, and `frame_done` pulses if the channel was 7. Next state is LOAD if `enable`=1, otherwise IDLE.
- `enable` is sampled only in IDLE and at SETTLE exit. A channel in progress is never aborted.
- ch is preserved across IDLE, so refresh resumes at the next channel rather than restarting at 0.
- If a write to bank[ch] occurs in the same cycle as LOAD, LOAD captures the old value. The new value is output on the next visit to that channel.
- `dac_data` and `sh_addr` hold their last values outside LOAD.
- `dac_wr` and `sh_en` are never high in the same cycle.

## Timing
- Reset values: `dac_data`=0, `dac_wr`=0, `sh_addr`=0, `sh_en`=0, `busy`=0, `frame_done`=0, bank all 0, ch=0, state IDLE.
- Reset asserted mid-operation forces the reset values on the next edge, with no completion of the current channel.
- Latency:
  - `enable` high in IDLE at edge n: LOAD at n+1; `dac_wr` high from n+2 through n+1+STROBE_CYCLES.
  - `sh_en` high for the following SETTLE_CYCLES cycles.
- Per-channel period is 1+STROBE_CYCLES+SETTLE_CYCLES cycles; a frame is 8x that.
- One shared down-counter serves both STROBE and SETTLE. Its width is $clog2 of max(STROBE_CYCLES, SETTLE_CYCLES)+1, and it reloads on every state entry.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Configuration
- DAC_REFRESH_MASK_EN defined: adds input `ch_mask` (8 bits, 1 = channel active).
  - When advancing, ch moves to the next active channel in ascending order with wrap.
  - `frame_done` pulses when the advance wraps past channel 7.
  - If `ch_mask`=0 the FSM stays in or returns to IDLE, even with `enable`=1.
  - `ch_mask` is sampled at the same points as `enable`.
- Macro undefined: no `ch_mask` port; all 8 channels are visited in order.

## Structure
- Shared package holds:
  - state enum (IDLE/LOAD/STROBE/SETTLE);
  - localparams CH_W=3 and DATA_W=8, shared with the ADC input bank.
- One sub-module: `dac_setpoint_bank`, the 8x8 register file with one synchronous write port, one combinational read port, and synchronous reset.

## Test plan
- Reset, write ch3=0xA5, raise `enable`: LOAD for ch0 presents `dac_data`=0x00. When ch3 is reached, `dac_data`=0xA5, `sh_addr`=3, and `dac_wr` is high for 4 cycles before `sh_en` rises.
- Drop `enable` during ch5 SETTLE: ch5 completes its full SETTLE_CYCLES. The FSM then goes to IDLE with `busy`=0, and re-enabling starts at ch6.
- Write 0x3C to ch2 on the exact LOAD cycle of ch2: `dac_data` shows the old value. On the next frame's ch2 visit, `dac_data`=0x3C.
- Run a full frame with SETTLE_CYCLES=10: `frame_done` pulses once, exactly 8x15 cycles after the first LOAD, and ch wraps to 0.
- Assert `reset` during STROBE: the next cycle has every output at its reset value and `busy`=0, and the bank reads all zero.
- With DAC_REFRESH_MASK_EN and `ch_mask`=8'b1000_0010: only ch1 and ch7 are visited, `frame_done` pulses after ch7. With `ch_mask`=0, the FSM stays in IDLE.
